// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from MEM/WB and load-use bubble insertion.
// Feeds the ALU operands, op code and shift amount one cycle after decode.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [2:0]    id_aluop,
    input  logic [4:0]    id_shamt,
    input  logic          id_alusrc,
    input  logic          id_regdst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_uses_rt,
    input  logic          flush,
    input  logic          ex_hold,
    input  logic          mem_regwrite,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_regwrite,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_result,
    output logic          id_stall,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [2:0]    alu_op,
    output logic [4:0]    alu_shamt,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wreg,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite
);

    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic [RW-1:0] ex_rs, ex_rt;
    logic          alusrc_q;

    logic          load_use;
    logic          bubble;
    logic [DW-1:0] cap_rs_data, cap_rt_data;
    logic [DW-1:0] fwd_a, fwd_b;

    // NOTE: every signal written here gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        load_use = 1'b0;
        if (ex_valid && ex_memread && (ex_wreg != '0) && id_valid)
            load_use = (ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt));

        // A redirect kills the decode slot, so holding it would be pointless.
        id_stall = (load_use || ex_hold) && !flush;
        bubble   = flush || (!ex_hold && load_use);

        // WB writes the register file in the same cycle decode reads it.
        cap_rs_data = id_rs_data;
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs))
            cap_rs_data = wb_result;
        cap_rt_data = id_rt_data;
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rt))
            cap_rt_data = wb_result;

        fwd_a = rs_data_q;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs))
            fwd_a = mem_result;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs))
            fwd_a = wb_result;

        fwd_b = rt_data_q;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rt))
            fwd_b = mem_result;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rt))
            fwd_b = wb_result;

        alu_in1       = fwd_a;
        alu_in2       = alusrc_q ? imm_q : fwd_b;
        ex_store_data = fwd_b;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_wreg     <= '0;
            alu_op      <= '0;
            alu_shamt   <= '0;
            alusrc_q    <= 1'b0;
        end else if (bubble) begin
            // Only the controls matter for a bubble; datapath contents are left as they were.
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
        end else if (!ex_hold) begin
            ex_valid    <= id_valid;
            ex_regwrite <= id_valid && id_regwrite;
            ex_memread  <= id_valid && id_memread;
            ex_memwrite <= id_valid && id_memwrite;
            rs_data_q   <= cap_rs_data;
            rt_data_q   <= cap_rt_data;
            imm_q       <= id_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_wreg     <= id_regdst ? id_rd : id_rt;
            alu_op      <= id_aluop;
            alu_shamt   <= id_shamt;
            alusrc_q    <= id_alusrc;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table of capture/forwarding vectors through a scoreboard,
// plus hand sequences for bypass, load-use, hold, flush and mid-cycle reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_aluop;
    logic [4:0]  id_shamt;
    logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_uses_rt;
    logic        flush, ex_hold;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        id_stall;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [2:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [4:0]  ex_wreg;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop), .id_shamt(id_shamt),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_uses_rt(id_uses_rt),
        .flush(flush), .ex_hold(ex_hold),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .id_stall(id_stall), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_shamt(alu_shamt), .ex_store_data(ex_store_data), .ex_wreg(ex_wreg),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] in1, in2, store;
        logic [2:0]  op;
        logic [4:0]  shamt, wreg;
        logic        valid, regwrite, memwrite;
    } exp_t;

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic [2:0]  aluop;
        logic [4:0]  shamt;
        logic        alusrc, regdst, regwrite, memread, memwrite;
        logic        mem_rw;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
        exp_t        e;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, imm,
        input logic [2:0] op, input logic [4:0] sh, input logic asrc, rdst, rw, mr, mw,
        input logic m_rw, input logic [4:0] m_rd, input logic [31:0] m_res,
        input logic w_rw, input logic [4:0] w_rd, input logic [31:0] w_res,
        input logic [31:0] e_in1, e_in2, e_store, input logic [4:0] e_wreg,
        input logic e_valid, e_rw, e_mw);
        vec_t t;
        t.valid = v;  t.rs = rs;  t.rt = rt;  t.rd = rd;
        t.rs_data = rsd;  t.rt_data = rtd;  t.imm = imm;
        t.aluop = op;  t.shamt = sh;  t.alusrc = asrc;  t.regdst = rdst;
        t.regwrite = rw;  t.memread = mr;  t.memwrite = mw;
        t.mem_rw = m_rw;  t.mem_rd = m_rd;  t.mem_res = m_res;
        t.wb_rw = w_rw;  t.wb_rd = w_rd;  t.wb_res = w_res;
        t.e.in1 = e_in1;  t.e.in2 = e_in2;  t.e.store = e_store;
        t.e.op = op;  t.e.shamt = sh;  t.e.wreg = e_wreg;
        t.e.valid = e_valid;  t.e.regwrite = e_rw;  t.e.memwrite = e_mw;
        return t;
    endfunction

    task automatic drive_id(input logic v, input logic [4:0] rs, rt, rd,
                            input logic [31:0] rsd, rtd, imm, input logic [2:0] op,
                            input logic [4:0] sh, input logic asrc, rdst, rw, mr, mw, urt);
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_rd = rd;
        id_rs_data = rsd;  id_rt_data = rtd;  id_imm = imm;
        id_aluop = op;  id_shamt = sh;  id_alusrc = asrc;  id_regdst = rdst;
        id_regwrite = rw;  id_memread = mr;  id_memwrite = mw;  id_uses_rt = urt;
    endtask

    task automatic idle_fwd();
        mem_regwrite = 1'b0;  mem_rd = '0;  mem_result = '0;
        wb_regwrite  = 1'b0;  wb_rd  = '0;  wb_result  = '0;
    endtask

    initial begin
        exp_t e;

        //          v rs rt rd  rs_data      rt_data  imm            op sh as rd rw mr mw | mem fwd       | wb fwd      | in1 in2 store wreg v rw mw
        vecs[0] = mk(1, 1, 2, 3, 32'd5,   32'd7,   32'd0,         1, 0, 0, 1, 1, 0, 0, 0, 0, 32'd0,   0, 0, 32'd0,
                     32'd5,   32'd7,         32'd7,   5'd3,  1, 1, 0);
        vecs[1] = mk(1, 4, 5, 6, 32'd10,  32'd20,  32'hFFFF_FFF0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'd0,   0, 0, 32'd0,
                     32'd10,  32'hFFFF_FFF0, 32'd20,  5'd5,  1, 1, 0);
        vecs[2] = mk(1, 3, 7, 9, 32'd1,   32'd2,   32'd0,         2, 0, 0, 1, 1, 0, 0, 1, 3, 32'd9,   1, 3, 32'd4,
                     32'd9,   32'd2,         32'd2,   5'd9,  1, 1, 0);
        vecs[3] = mk(1, 3, 7, 9, 32'd1,   32'd2,   32'd0,         2, 0, 0, 1, 1, 0, 0, 0, 3, 32'd9,   1, 3, 32'd4,
                     32'd4,   32'd2,         32'd2,   5'd9,  1, 1, 0);
        vecs[4] = mk(1, 0, 8, 10, 32'd55, 32'd66,  32'd0,         3, 0, 0, 1, 1, 0, 0, 1, 0, 32'd9,   1, 0, 32'd4,
                     32'd55,  32'd66,        32'd66,  5'd10, 1, 1, 0);
        vecs[5] = mk(1, 2, 6, 11, 32'd3,  32'd5,   32'd16,        4, 0, 1, 0, 1, 0, 0, 1, 6, 32'hAB,  0, 0, 32'd0,
                     32'd3,   32'd16,        32'hAB,  5'd6,  1, 1, 0);
        vecs[6] = mk(0, 1, 2, 12, 32'd8,  32'd9,   32'd0,         5, 0, 0, 1, 1, 0, 1, 0, 0, 32'd0,   0, 0, 32'd0,
                     32'd8,   32'd9,         32'd9,   5'd12, 0, 0, 0);
        vecs[7] = mk(1, 9, 10, 13, 32'd100, 32'd200, 32'd0,       7, 31, 0, 1, 0, 0, 1, 0, 0, 32'd0,  0, 0, 32'd0,
                     32'd100, 32'd200,       32'd200, 5'd13, 1, 0, 1);

        // Reset state
        rst_n = 1'b0;  flush = 1'b0;  ex_hold = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_fwd();
        #1;
        check("reset_ex_valid", ex_valid, 0);
        check("reset_alu_in1", alu_in1, 0);
        check("reset_alu_in2", alu_in2, 0);
        check("reset_id_stall", id_stall, 0);
        check("reset_regwrite", ex_regwrite, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: capture at one edge, EX-stage forwarding sources applied just after it
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rs_data,
                     vecs[i].rt_data, vecs[i].imm, vecs[i].aluop, vecs[i].shamt, vecs[i].alusrc,
                     vecs[i].regdst, vecs[i].regwrite, vecs[i].memread, vecs[i].memwrite, 1'b1);
            idle_fwd();
            sb.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            mem_regwrite = vecs[i].mem_rw;  mem_rd = vecs[i].mem_rd;  mem_result = vecs[i].mem_res;
            wb_regwrite  = vecs[i].wb_rw;   wb_rd  = vecs[i].wb_rd;   wb_result  = vecs[i].wb_res;
            #1;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: vector %0d has no expected entry", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_alu_in1", i), alu_in1, e.in1);
                check($sformatf("v%0d_alu_in2", i), alu_in2, e.in2);
                check($sformatf("v%0d_store", i), ex_store_data, e.store);
                check($sformatf("v%0d_alu_op", i), {29'd0, alu_op}, {29'd0, e.op});
                check($sformatf("v%0d_shamt", i), {27'd0, alu_shamt}, {27'd0, e.shamt});
                check($sformatf("v%0d_wreg", i), {27'd0, ex_wreg}, {27'd0, e.wreg});
                check($sformatf("v%0d_valid", i), ex_valid, e.valid);
                check($sformatf("v%0d_regwrite", i), ex_regwrite, e.regwrite);
                check($sformatf("v%0d_memwrite", i), ex_memwrite, e.memwrite);
            end
        end

        // Capture-time bypass from WB on both operands
        @(negedge clk);
        drive_id(1, 4, 4, 1, 32'h11, 32'h22, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        idle_fwd();
        wb_regwrite = 1'b1;  wb_rd = 5'd4;  wb_result = 32'h77;
        @(posedge clk);
        #1 wb_regwrite = 1'b0;
        #1;
        check("capbyp_in1", alu_in1, 32'h77);
        check("capbyp_in2", alu_in2, 32'h77);

        // Index 0 is never bypassed or forwarded
        @(negedge clk);
        drive_id(1, 0, 0, 1, 32'h11, 32'h22, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        wb_regwrite = 1'b1;  wb_rd = 5'd0;  wb_result = 32'h77;
        @(posedge clk);
        #1;
        check("zero_in1", alu_in1, 32'h11);
        check("zero_in2", alu_in2, 32'h22);

        // Load-use: lw $2, then add using $2 -> one bubble, then WB forwarding
        @(negedge clk);
        idle_fwd();
        drive_id(1, 1, 2, 0, 32'h0, 32'h0, 32'h4, 0, 0, 1, 0, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        check("lw_memread", ex_memread, 1);
        check("lw_wreg", {27'd0, ex_wreg}, 32'd2);
        @(negedge clk);
        drive_id(1, 2, 3, 4, 32'hDEAD, 32'h33, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        #1 check("lu_stall", id_stall, 1);
        @(posedge clk);
        #1;
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_regwrite", ex_regwrite, 0);
        check("lu_stall_released", id_stall, 0);
        mem_regwrite = 1'b1;  mem_rd = 5'd2;  mem_result = 32'h0;
        @(posedge clk);
        #1;
        mem_regwrite = 1'b0;
        wb_regwrite = 1'b1;  wb_rd = 5'd2;  wb_result = 32'h1234;
        #1;
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_in1", alu_in1, 32'h1234);
        check("lu_add_in2", alu_in2, 32'h33);
        check("lu_add_wreg", {27'd0, ex_wreg}, 32'd4);

        // Load-use boundaries: rt not a source, rt a source, load to $0
        @(negedge clk);
        idle_fwd();
        drive_id(1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive_id(1, 1, 5, 6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        #1 check("lu_rt_unused", id_stall, 0);
        id_uses_rt = 1'b1;
        #1 check("lu_rt_used", id_stall, 1);
        drive_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1);
        @(posedge clk);
        @(negedge clk);
        drive_id(1, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        #1 check("lu_dest_zero", id_stall, 0);

        // flush together with ex_hold loads a bubble
        @(negedge clk);
        drive_id(1, 1, 2, 3, 32'h31, 32'h41, 0, 2, 0, 0, 1, 1, 0, 0, 1);
        @(posedge clk);
        #1 check("pre_flush_valid", ex_valid, 1);
        @(negedge clk);
        flush = 1'b1;  ex_hold = 1'b1;
        @(posedge clk);
        #1;
        check("flush_hold_valid", ex_valid, 0);
        check("flush_hold_regwrite", ex_regwrite, 0);

        // ex_hold alone for three cycles
        @(negedge clk);
        flush = 1'b0;  ex_hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ex_hold = 1'b1;
        drive_id(1, 1, 2, 3, 32'h99, 32'h88, 0, 5, 0, 0, 1, 1, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_in1", c), alu_in1, 32'h31);
            check($sformatf("hold%0d_op", c), {29'd0, alu_op}, 32'd2);
            check($sformatf("hold%0d_valid", c), ex_valid, 1);
            check($sformatf("hold%0d_stall", c), id_stall, 1);
        end
        @(negedge clk);
        ex_hold = 1'b0;
        @(posedge clk);
        #1;
        check("post_hold_in1", alu_in1, 32'h99);
        check("post_hold_stall", id_stall, 0);

        // flush alone
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 check("flush_valid", ex_valid, 0);
        @(negedge clk);
        flush = 1'b0;

        // Asynchronous reset in the middle of a hold
        drive_id(1, 1, 2, 3, 32'h55, 32'h66, 0, 1, 0, 0, 1, 1, 0, 0, 1);
        @(posedge clk);
        #1 check("pre_reset_valid", ex_valid, 1);
        ex_hold = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", ex_valid, 0);
        check("midrst_in1", alu_in1, 0);
        check("midrst_in2", alu_in2, 0);
        check("midrst_store", ex_store_data, 0);
        check("midrst_regwrite", ex_regwrite, 0);
        ex_hold = 1'b0;
        #1 check("midrst_stall", id_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
